// File: rtl/rob_wb_arbiter_if.sv
// Request/completion bundle between writeback units, the arbiter and the ROB.
// The master side drives requests and the kill bus; the slave side is the arbiter.
interface rob_wb_arbiter_if #(
   parameter int WIDTH_BANK = 3,
   parameter int WIDTH_BRM  = 4,
   parameter int N_REQ      = 6
);
   localparam int WIDTH_TAG  = WIDTH_BANK + 2;
   localparam int WIDTH_BRST = 1 + WIDTH_TAG;

   logic [N_REQ-1:0]           req_valid;
   logic [N_REQ*WIDTH_TAG-1:0] req_tag;
   logic [N_REQ*WIDTH_BRM-1:0] req_brm;
   logic [N_REQ-1:0]           req_ready;
   logic [WIDTH_BRM:0]         kill;
   logic [WIDTH_BRST-1:0]      rst_busy0;
   logic [WIDTH_BRST-1:0]      rst_busy1;
   logic [WIDTH_BRST-1:0]      rst_busy2;
   logic [WIDTH_BRST-1:0]      rst_busy3;

   modport master (
      output req_valid, req_tag, req_brm, kill,
      input  req_ready, rst_busy0, rst_busy1, rst_busy2, rst_busy3
   );

   modport slave (
      input  req_valid, req_tag, req_brm, kill,
      output req_ready, rst_busy0, rst_busy1, rst_busy2, rst_busy3
   );
endinterface

// File: rtl/rob_wb_arbiter.sv
// Rotating-priority arbiter packing up to four writeback completions per cycle
// into registered ROB busy-clear lanes, with branch-kill squashing.
module rob_wb_arbiter #(
   parameter int WIDTH_BANK = 3,
   parameter int WIDTH_BRM  = 4,
   parameter int N_REQ      = 6
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   rob_wb_arbiter_if.slave  bus
);
   localparam int WIDTH_TAG  = WIDTH_BANK + 2;
   localparam int WIDTH_BRST = 1 + WIDTH_TAG;
   localparam int WIDTH_PTR  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int N_LANE     = 4;

   logic [WIDTH_PTR-1:0] ptr_r;
   logic [WIDTH_PTR-1:0] ptr_nxt_s;
   logic                 lane_en_r  [N_LANE];
   logic [WIDTH_TAG-1:0] lane_tag_r [N_LANE];
   logic [WIDTH_BRM-1:0] lane_brm_r [N_LANE];
   logic                 lane_en_s  [N_LANE];
   logic [WIDTH_TAG-1:0] lane_tag_s [N_LANE];
   logic [WIDTH_BRM-1:0] lane_brm_s [N_LANE];
   logic [WIDTH_PTR-1:0] lane_sel_s [N_LANE];

   logic [WIDTH_TAG-1:0] req_tag_s [N_REQ];
   logic [WIDTH_BRM-1:0] req_brm_s [N_REQ];
   logic [N_REQ-1:0]     killed_s;
   logic [N_REQ-1:0]     live_s;
   logic [N_REQ-1:0]     grant_s;
   logic [WIDTH_PTR-1:0] last_s;
   logic                 any_s;
   logic                 kill_en_s;
   logic [WIDTH_BRM-1:0] kill_mask_s;

   // Gate a registered lane with the current kill and zero the tag when not enabled.
   function automatic logic [WIDTH_BRST-1:0] pack_busy(
      input logic                 en,
      input logic [WIDTH_TAG-1:0] tag,
      input logic [WIDTH_BRM-1:0] brm,
      input logic                 k_en,
      input logic [WIDTH_BRM-1:0] k_mask
   );
      logic live;
      live = en & ~(k_en & (|(brm & k_mask)));
      return live ? {1'b1, tag} : {WIDTH_BRST{1'b0}};
   endfunction

   // Unpack per-requester fields and evaluate kills ahead of arbitration.
   always_comb begin
      kill_en_s   = bus.kill[WIDTH_BRM];
      kill_mask_s = bus.kill[WIDTH_BRM-1:0];
      for (int k = 0; k < N_REQ; k++) begin
         req_tag_s[k] = bus.req_tag[k*WIDTH_TAG +: WIDTH_TAG];
         req_brm_s[k] = bus.req_brm[k*WIDTH_BRM +: WIDTH_BRM];
         killed_s[k]  = bus.req_valid[k] & kill_en_s & (|(req_brm_s[k] & kill_mask_s));
      end
      live_s = bus.req_valid & ~killed_s;
   end

   // Scan live requests from ptr upward, granting the first four in scan order.
   always_comb begin
      logic [WIDTH_PTR:0]   idx;
      logic [WIDTH_PTR-1:0] sel;
      logic [2:0]           cnt;
      grant_s = '0;
      last_s  = '0;
      any_s   = 1'b0;
      cnt     = 3'd0;
      idx     = '0;
      sel     = '0;
      for (int l = 0; l < N_LANE; l++) begin
         lane_sel_s[l] = '0;
         lane_en_s[l]  = 1'b0;
      end
      for (int i = 0; i < N_REQ; i++) begin
         idx = {1'b0, ptr_r} + (WIDTH_PTR+1)'(i);
         if (idx >= (WIDTH_PTR+1)'(N_REQ)) begin
            idx = idx - (WIDTH_PTR+1)'(N_REQ);
         end else begin
            idx = idx;
         end
         sel = idx[WIDTH_PTR-1:0];
         if (live_s[sel] && (cnt < 3'd4)) begin
            grant_s[sel]          = 1'b1;
            lane_sel_s[cnt[1:0]]  = sel;
            lane_en_s[cnt[1:0]]   = 1'b1;
            last_s                = sel;
            any_s                 = 1'b1;
            cnt                   = cnt + 3'd1;
         end else begin
            cnt = cnt;
         end
      end
   end

   // Lane payloads, pointer advance and the consumed-request handshake.
   always_comb begin
      for (int l = 0; l < N_LANE; l++) begin
         if (lane_en_s[l]) begin
            lane_tag_s[l] = req_tag_s[lane_sel_s[l]];
            lane_brm_s[l] = req_brm_s[lane_sel_s[l]];
         end else begin
            lane_tag_s[l] = '0;
            lane_brm_s[l] = '0;
         end
      end
      if (!any_s) begin
         ptr_nxt_s = ptr_r;
      end else if (last_s == WIDTH_PTR'(N_REQ - 1)) begin
         ptr_nxt_s = '0;
      end else begin
         ptr_nxt_s = last_s + WIDTH_PTR'(1);
      end
      bus.req_ready = grant_s | killed_s;
   end

   // Every lane reloads each cycle, so a lane squashed by kill is simply overwritten.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ptr_r <= '0;
         for (int l = 0; l < N_LANE; l++) begin
            lane_en_r[l]  <= 1'b0;
            lane_tag_r[l] <= '0;
            lane_brm_r[l] <= '0;
         end
      end else begin
         ptr_r <= ptr_nxt_s;
         for (int l = 0; l < N_LANE; l++) begin
            lane_en_r[l]  <= lane_en_s[l];
            lane_tag_r[l] <= lane_tag_s[l];
            lane_brm_r[l] <= lane_brm_s[l];
         end
      end
   end

   assign bus.rst_busy0 = pack_busy(lane_en_r[0], lane_tag_r[0], lane_brm_r[0], kill_en_s, kill_mask_s);
   assign bus.rst_busy1 = pack_busy(lane_en_r[1], lane_tag_r[1], lane_brm_r[1], kill_en_s, kill_mask_s);
   assign bus.rst_busy2 = pack_busy(lane_en_r[2], lane_tag_r[2], lane_brm_r[2], kill_en_s, kill_mask_s);
   assign bus.rst_busy3 = pack_busy(lane_en_r[3], lane_tag_r[3], lane_brm_r[3], kill_en_s, kill_mask_s);
endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Directed bench for rob_wb_arbiter: vector table for arbitration/kill cases
// plus hand sequences for lane squash and mid-stream reset.
module tb_rob_wb_arbiter;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   rob_wb_arbiter_if #(.WIDTH_BANK(3), .WIDTH_BRM(4), .N_REQ(6)) bus ();

   rob_wb_arbiter #(.WIDTH_BANK(3), .WIDTH_BRM(4), .N_REQ(6)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [4:0] tag_tbl [6];

   typedef struct {
      logic [5:0]  valid;
      logic [23:0] brm;
      logic [4:0]  kill;
      logic [5:0]  ready;
      int          l0, l1, l2, l3;
   } vec_t;

   vec_t vecs [13];

   function automatic logic [5:0] exp_busy(input int r);
      logic [5:0] v;
      v = (r < 0) ? 6'd0 : {1'b1, tag_tbl[r]};
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic check_lanes(input string tag, input int l0, input int l1, input int l2, input int l3);
      check({tag, ".busy0"}, 32'(bus.rst_busy0), 32'(exp_busy(l0)));
      check({tag, ".busy1"}, 32'(bus.rst_busy1), 32'(exp_busy(l1)));
      check({tag, ".busy2"}, 32'(bus.rst_busy2), 32'(exp_busy(l2)));
      check({tag, ".busy3"}, 32'(bus.rst_busy3), 32'(exp_busy(l3)));
   endtask

   initial begin
      checks = 0;
      errors = 0;
      tag_tbl[0] = 5'b000_11;
      tag_tbl[1] = 5'b011_00;
      tag_tbl[2] = 5'b010_10;
      tag_tbl[3] = 5'b100_01;
      tag_tbl[4] = 5'b101_10;
      tag_tbl[5] = 5'b001_01;

      // ptr before each vector: 0,4,2,0,4,0,0,4,4,4,4,2,2
      vecs[0]  = '{6'b111111, 24'h000000, 5'b00000, 6'b001111,  0,  1,  2,  3};
      vecs[1]  = '{6'b111111, 24'h000000, 5'b00000, 6'b110011,  4,  5,  0,  1};
      vecs[2]  = '{6'b111111, 24'h000000, 5'b00000, 6'b111100,  2,  3,  4,  5};
      vecs[3]  = '{6'b111111, 24'h000000, 5'b00000, 6'b001111,  0,  1,  2,  3};
      vecs[4]  = '{6'b100000, 24'h000000, 5'b00000, 6'b100000,  5, -1, -1, -1};
      vecs[5]  = '{6'b100101, 24'h000000, 5'b00000, 6'b100101,  0,  2,  5, -1};
      vecs[6]  = '{6'b001111, 24'h000020, 5'b10010, 6'b001111,  0,  2,  3, -1};
      vecs[7]  = '{6'b000000, 24'h000000, 5'b00000, 6'b000000, -1, -1, -1, -1};
      vecs[8]  = '{6'b000110, 24'h000130, 5'b10001, 6'b000110, -1, -1, -1, -1};
      vecs[9]  = '{6'b001000, 24'h00F000, 5'b01111, 6'b001000,  3, -1, -1, -1};
      vecs[10] = '{6'b010011, 24'h000000, 5'b00000, 6'b010011,  4,  0,  1, -1};
      vecs[11] = '{6'b000011, 24'h000008, 5'b11000, 6'b000011,  1, -1, -1, -1};
      vecs[12] = '{6'b111111, 24'h404000, 5'b10100, 6'b111111,  2,  4,  0,  1};

      rst_n         = 1'b0;
      bus.req_valid = 6'b111111;
      bus.req_tag   = {tag_tbl[5], tag_tbl[4], tag_tbl[3], tag_tbl[2], tag_tbl[1], tag_tbl[0]};
      bus.req_brm   = 24'h000000;
      bus.kill      = 5'b00000;
      repeat (2) @(posedge clk);
      #1;
      check_lanes("reset", -1, -1, -1, -1);
      @(negedge clk);
      bus.req_valid = 6'b000000;
      rst_n         = 1'b1;

      for (int v = 0; v < 13; v++) begin
         @(negedge clk);
         bus.req_valid = vecs[v].valid;
         bus.req_brm   = vecs[v].brm;
         bus.kill      = vecs[v].kill;
         #1;
         check($sformatf("vec%0d.ready", v), 32'(bus.req_ready), 32'(vecs[v].ready));
         @(posedge clk);
         #1;
         bus.req_valid = 6'b000000;
         bus.req_brm   = 24'h000000;
         bus.kill      = 5'b00000;
         #1;
         check_lanes($sformatf("vec%0d", v), vecs[v].l0, vecs[v].l1, vecs[v].l2, vecs[v].l3);
      end

      // Lane squash: ptr=2, requester 0 is the only one and lands in lane 0.
      @(negedge clk);
      bus.req_valid = 6'b000001;
      bus.req_brm   = 24'h000004;
      @(posedge clk);
      #1;
      bus.req_valid = 6'b000000;
      bus.req_brm   = 24'h000000;
      bus.kill      = 5'b10100;
      #1;
      check_lanes("squash_hit", -1, -1, -1, -1);
      bus.kill = 5'b11000;
      #1;
      check_lanes("squash_miss", 0, -1, -1, -1);
      @(posedge clk);
      #1;
      bus.kill = 5'b00000;
      #1;
      check_lanes("squash_after", -1, -1, -1, -1);

      // Mid-stream reset: ptr=1, fill lanes, then reset between edges.
      @(negedge clk);
      bus.req_valid = 6'b111111;
      @(posedge clk);
      #1;
      check_lanes("pre_reset", 1, 2, 3, 4);
      rst_n = 1'b0;
      #1;
      check_lanes("mid_reset", -1, -1, -1, -1);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_reset.ready", 32'(bus.req_ready), 32'(6'b001111));
      @(posedge clk);
      #1;
      bus.req_valid = 6'b000000;
      #1;
      check_lanes("post_reset", 0, 1, 2, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
